// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and pin sequencer for a 256Kx16 asynchronous SRAM.
//   Port A has fixed priority; port B is forced after STARVE_MAX consecutive A grants
//   while B is waiting. Each granted req/ack transaction becomes a timed
//   CEn/OEn/WEn/LBn/UBn/DEn sequence. Every output is driven straight from a flop.
// Ports:
//   iCLK, iRST_N                  clock, asynchronous active-low reset
//   a_*/b_* req,we,be,addr,wdata  requester side; fields held stable until ack
//   a_ack/b_ack                   one-cycle completion pulse
//   a_rdata/b_rdata               read data, valid with ack, held until that port's next read
//   SRAM_ADDR, SRAM_*n            registered SRAM address and active-low strobes
//   SRAM_DEn, SRAM_Dout           bus drive enable (0 = drive) and write data
//   SRAM_Din                      bus read data
module sram_arbiter #(
  parameter int unsigned ADDR_W     = 18,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned RD_CYC     = 2,
  parameter int unsigned WR_CYC     = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_be,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_be,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic              SRAM_CEn,
  output logic              SRAM_OEn,
  output logic              SRAM_WEn,
  output logic              SRAM_LBn,
  output logic              SRAM_UBn,
  output logic              SRAM_DEn,
  output logic [DATA_W-1:0] SRAM_Dout,
  input  logic [DATA_W-1:0] SRAM_Din
);

  localparam int unsigned CYC_MAX = (RD_CYC > WR_CYC) ? RD_CYC : WR_CYC;
  localparam int unsigned CYC_W   = (CYC_MAX < 2) ? 1 : $clog2(CYC_MAX);
  localparam int unsigned CNT_W   = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WR   = 3'd2,
    S_RACK = 3'd3,
    S_WACK = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gnt_b_q, gnt_b_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                cen_q, cen_d;
  logic                oen_q, oen_d;
  logic                wen_q, wen_d;
  logic                lbn_q, lbn_d;
  logic                ubn_q, ubn_d;
  logic                den_q, den_d;
  logic                a_ack_q, a_ack_d;
  logic                b_ack_q, b_ack_d;
  logic [DATA_W-1:0]   a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0]   b_rdata_q, b_rdata_d;

  logic                grant_a, grant_b;
  logic                sel_we;
  logic [1:0]          sel_be;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // State and output registers
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      cnt_q     <= '0;
      gnt_b_q   <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      cen_q     <= 1'b1;
      oen_q     <= 1'b1;
      wen_q     <= 1'b1;
      lbn_q     <= 1'b1;
      ubn_q     <= 1'b1;
      den_q     <= 1'b1;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      cnt_q     <= cnt_d;
      gnt_b_q   <= gnt_b_d;
      addr_q    <= addr_d;
      dout_q    <= dout_d;
      cen_q     <= cen_d;
      oen_q     <= oen_d;
      wen_q     <= wen_d;
      lbn_q     <= lbn_d;
      ubn_q     <= ubn_d;
      den_q     <= den_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  // Next-state, grant, starvation counter and pin sequencing
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    cnt_d     = cnt_q;
    gnt_b_d   = gnt_b_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    cen_d     = cen_q;
    oen_d     = oen_q;
    wen_d     = wen_q;
    lbn_d     = lbn_q;
    ubn_d     = ubn_q;
    den_d     = den_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    grant_a   = 1'b0;
    grant_b   = 1'b0;

    // A wins unless B has already watched STARVE_MAX A grants go by
    if (state_q == S_IDLE) begin
      grant_a = a_req && !(b_req && (cnt_q == CNT_W'(STARVE_MAX)));
      grant_b = !grant_a && b_req;
    end

    sel_we    = grant_b ? b_we    : a_we;
    sel_be    = grant_b ? b_be    : a_be;
    sel_addr  = grant_b ? b_addr  : a_addr;
    sel_wdata = grant_b ? b_wdata : a_wdata;

    unique case (state_q)
      S_IDLE: begin
        if (grant_a || grant_b) begin
          gnt_b_d = grant_b;
          addr_d  = sel_addr;
          cen_d   = 1'b0;
          lbn_d   = ~sel_be[0];
          ubn_d   = ~sel_be[1];
          cyc_d   = '0;
          if (sel_we) begin
            wen_d   = 1'b0;
            den_d   = 1'b0;
            dout_d  = sel_wdata;
            state_d = S_WR;
          end else begin
            oen_d   = 1'b0;
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        if (cyc_q == CYC_W'(RD_CYC - 1)) begin
          if (gnt_b_q) begin
            b_rdata_d = SRAM_Din;
            b_ack_d   = 1'b1;
          end else begin
            a_rdata_d = SRAM_Din;
            a_ack_d   = 1'b1;
          end
          cen_d   = 1'b1;
          oen_d   = 1'b1;
          lbn_d   = 1'b1;
          ubn_d   = 1'b1;
          state_d = S_RACK;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_WR: begin
        // DEn stays low through WACK so data is held past the WEn rising edge
        if (cyc_q == CYC_W'(WR_CYC - 1)) begin
          if (gnt_b_q) begin
            b_ack_d = 1'b1;
          end else begin
            a_ack_d = 1'b1;
          end
          wen_d   = 1'b1;
          cen_d   = 1'b1;
          lbn_d   = 1'b1;
          ubn_d   = 1'b1;
          state_d = S_WACK;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_RACK: begin
        state_d = S_IDLE;
      end
      S_WACK: begin
        den_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (grant_b) begin
      cnt_d = '0;
    end else if (grant_a && b_req) begin
      if (cnt_q != CNT_W'(STARVE_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (!b_req) begin
      cnt_d = '0;
    end
  end

  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign SRAM_ADDR = addr_q;
  assign SRAM_CEn  = cen_q;
  assign SRAM_OEn  = oen_q;
  assign SRAM_WEn  = wen_q;
  assign SRAM_LBn  = lbn_q;
  assign SRAM_UBn  = ubn_q;
  assign SRAM_DEn  = den_q;
  assign SRAM_Dout = dout_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: self-checking bench for sram_arbiter with a behavioural SRAM model,
//   a pin monitor and per-port scoreboards of expected read data.
module tb_sram_arbiter;

  logic        iCLK;
  logic        iRST_N;
  logic        a_req, a_we, b_req, b_we;
  logic [1:0]  a_be, b_be;
  logic [17:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_CEn, SRAM_OEn, SRAM_WEn, SRAM_LBn, SRAM_UBn, SRAM_DEn;
  logic [15:0] SRAM_Dout;
  logic [15:0] SRAM_Din;

  sram_arbiter dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_be      (a_be),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_be      (b_be),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_CEn  (SRAM_CEn),
    .SRAM_OEn  (SRAM_OEn),
    .SRAM_WEn  (SRAM_WEn),
    .SRAM_LBn  (SRAM_LBn),
    .SRAM_UBn  (SRAM_UBn),
    .SRAM_DEn  (SRAM_DEn),
    .SRAM_Dout (SRAM_Dout),
    .SRAM_Din  (SRAM_Din)
  );

  initial iCLK = 1'b0;
  always #10 iCLK = ~iCLK;

  // Content of a location never written: a fixed pattern, 0xBEEF at 0x12345
  function automatic logic [15:0] init_val(input logic [17:0] a);
    if (a == 18'h12345) return 16'hBEEF;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // SRAM model: byte-lane writes while CEn/WEn/DEn are low, read data while CEn/OEn are low
  logic [15:0] mem     [0:262143];
  bit          written [0:262143];
  logic [15:0] din_q = 16'h0000;
  assign SRAM_Din = din_q;

  always @(negedge iCLK) begin
    logic [15:0] cur;
    cur = written[SRAM_ADDR] ? mem[SRAM_ADDR] : init_val(SRAM_ADDR);
    if (!SRAM_CEn && !SRAM_WEn && !SRAM_DEn) begin
      mem[SRAM_ADDR]     <= {SRAM_UBn ? cur[15:8] : SRAM_Dout[15:8],
                             SRAM_LBn ? cur[7:0]  : SRAM_Dout[7:0]};
      written[SRAM_ADDR] <= 1'b1;
    end
    din_q <= (!SRAM_CEn && !SRAM_OEn) ? cur : 16'h0000;
  end

  // Pin monitor
  int   cyc = 0;
  int   oe_low = 0, we_low = 0, den_low = 0, conflicts = 0;
  int   a_ack_cnt = 0, b_ack_cnt = 0;
  int   den_rise_cyc = 0, oen_fall_cyc = 0;
  logic last_lbn = 1'b1, last_ubn = 1'b1;
  logic [15:0] last_dout = 16'h0;
  logic prev_cen = 1'b1, prev_oen = 1'b1, prev_den = 1'b1;
  int   grant_cyc[$];
  int   a_ack_cyc[$];
  bit   ack_log[$];

  always @(negedge iCLK) begin
    cyc <= cyc + 1;
    if (!SRAM_OEn) oe_low <= oe_low + 1;
    if (!SRAM_WEn) we_low <= we_low + 1;
    if (!SRAM_DEn) begin
      den_low   <= den_low + 1;
      last_dout <= SRAM_Dout;
    end
    if (!SRAM_OEn && !SRAM_DEn) conflicts <= conflicts + 1;
    if (!SRAM_CEn) begin
      last_lbn <= SRAM_LBn;
      last_ubn <= SRAM_UBn;
    end
    if (prev_cen && !SRAM_CEn) grant_cyc.push_back(cyc);
    if (!prev_den && SRAM_DEn) den_rise_cyc <= cyc;
    if (prev_oen && !SRAM_OEn) oen_fall_cyc <= cyc;
    if (a_ack) begin
      a_ack_cnt <= a_ack_cnt + 1;
      a_ack_cyc.push_back(cyc);
      ack_log.push_back(1'b0);
    end
    if (b_ack) begin
      b_ack_cnt <= b_ack_cnt + 1;
      ack_log.push_back(1'b1);
    end
    prev_cen <= SRAM_CEn;
    prev_oen <= SRAM_OEn;
    prev_den <= SRAM_DEn;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [15:0] exp;
  } sb_t;
  sb_t sb_a[$];
  sb_t sb_b[$];

  // Issue one request (called at a falling edge), wait for ack, score the result
  task automatic txn(input bit port, input logic we, input logic [1:0] be,
                     input logic [17:0] addr, input logic [15:0] wdata,
                     input logic [15:0] exp, input bit keep, input string name);
    sb_t e;
    bit  got;
    e.we  = we;
    e.exp = exp;
    if (!port) begin
      a_we = we; a_be = be; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
      sb_a.push_back(e);
    end else begin
      b_we = we; b_be = be; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
      sb_b.push_back(e);
    end
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge iCLK);
      if (port ? b_ack : a_ack) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no ack within 64 cycles, ack required", name);
      if (port) void'(sb_b.pop_front()); else void'(sb_a.pop_front());
    end else begin
      e = port ? sb_b.pop_front() : sb_a.pop_front();
      if (!e.we) chk({name, "_rdata"}, 32'(port ? b_rdata : a_rdata), 32'(e.exp));
      chk({name, "_other_ack"}, 32'(port ? a_ack : b_ack), 32'd0);
    end
    if (!keep) begin
      if (port) b_req = 1'b0; else a_req = 1'b0;
    end
  endtask

  typedef struct {
    bit          port;
    logic        we;
    logic [1:0]  be;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   s_oe, s_we, s_den, s_aack, s_back, n0;
    bit   exp_order[10];

    // Byte-enable read-back vectors: {port, we, be, addr, wdata, expected rdata}
    tbl[0] = '{1'b0, 1'b1, 2'b11, 18'h00100, 16'h1111, 16'h0000};
    tbl[1] = '{1'b0, 1'b0, 2'b11, 18'h00100, 16'h0000, 16'h1111};
    tbl[2] = '{1'b1, 1'b1, 2'b01, 18'h00100, 16'hAB22, 16'h0000};
    tbl[3] = '{1'b1, 1'b0, 2'b11, 18'h00100, 16'h0000, 16'h1122};
    tbl[4] = '{1'b0, 1'b1, 2'b00, 18'h00100, 16'hFFFF, 16'h0000};
    tbl[5] = '{1'b0, 1'b0, 2'b11, 18'h00100, 16'h0000, 16'h1122};
    tbl[6] = '{1'b1, 1'b1, 2'b10, 18'h00100, 16'hCC99, 16'h0000};
    tbl[7] = '{1'b0, 1'b0, 2'b11, 18'h00100, 16'h0000, 16'hCC22};
    tbl[8] = '{1'b1, 1'b0, 2'b11, 18'h00777, 16'h0000, 16'h5D2D};
    tbl[9] = '{1'b0, 1'b0, 2'b11, 18'h3FFFF, 16'h0000, 16'hA5A5};
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    iRST_N = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_be = 2'b00; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_be = 2'b00; b_addr = '0; b_wdata = '0;
    repeat (3) @(negedge iCLK);

    // Reset state
    chk("rst_strobes", 32'({SRAM_CEn, SRAM_OEn, SRAM_WEn, SRAM_LBn, SRAM_UBn, SRAM_DEn}), 32'h3F);
    chk("rst_addr", 32'(SRAM_ADDR), 32'd0);
    chk("rst_dout", 32'(SRAM_Dout), 32'd0);
    chk("rst_acks", 32'({a_ack, b_ack}), 32'd0);
    chk("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    iRST_N = 1'b1;
    repeat (2) @(negedge iCLK);

    // Single A read of the preloaded 0xBEEF location
    s_oe = oe_low; s_aack = a_ack_cnt; s_back = b_ack_cnt;
    txn(1'b0, 1'b0, 2'b11, 18'h12345, 16'h0000, 16'hBEEF, 1'b0, "t1");
    repeat (3) @(negedge iCLK);
    chk("t1_oe_low_cycles", 32'(oe_low - s_oe), 32'd2);
    chk("t1_lbn_ubn", 32'({last_lbn, last_ubn}), 32'd0);
    chk("t1_a_ack_count", 32'(a_ack_cnt - s_aack), 32'd1);
    chk("t1_ack_latency", 32'(a_ack_cyc[$] - grant_cyc[$]), 32'd2);
    chk("t1_b_untouched", 32'({b_ack_cnt - s_back, 16'(b_rdata)}), 32'd0);

    // Single B upper-byte write
    s_we = we_low; s_den = den_low; s_back = b_ack_cnt;
    txn(1'b1, 1'b1, 2'b10, 18'h00201, 16'hA55A, 16'h0000, 1'b0, "t2");
    repeat (3) @(negedge iCLK);
    chk("t2_we_low_cycles", 32'(we_low - s_we), 32'd2);
    chk("t2_den_low_cycles", 32'(den_low - s_den), 32'd3);
    chk("t2_lbn_ubn", 32'({last_lbn, last_ubn}), 32'b10);
    chk("t2_dout", 32'(last_dout), 32'hA55A);
    chk("t2_b_ack_count", 32'(b_ack_cnt - s_back), 32'd1);
    txn(1'b1, 1'b0, 2'b11, 18'h00201, 16'h0000, 16'hA55B, 1'b0, "t2_readback");
    repeat (3) @(negedge iCLK);

    // Table of byte-enable writes and read-backs
    foreach (tbl[i]) begin
      txn(tbl[i].port, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, tbl[i].exp,
          1'b0, $sformatf("vec%0d", i));
      @(negedge iCLK);
    end
    repeat (3) @(negedge iCLK);

    // Both ports held busy: starvation limit forces B after four A grants
    n0 = ack_log.size();
    fork
      begin
        for (int i = 0; i < 8; i++)
          txn(1'b0, 1'b0, 2'b11, 18'h02000 + 18'(i), 16'h0, init_val(18'h02000 + 18'(i)),
              i < 7, $sformatf("t3a%0d", i));
      end
      begin
        for (int j = 0; j < 2; j++)
          txn(1'b1, 1'b0, 2'b11, 18'h03000 + 18'(j), 16'h0, init_val(18'h03000 + 18'(j)),
              j < 1, $sformatf("t3b%0d", j));
      end
    join
    repeat (3) @(negedge iCLK);
    chk("t3_ack_total", 32'(ack_log.size() - n0), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (n0 + k < ack_log.size())
        chk($sformatf("t3_grant_order%0d", k), 32'(ack_log[n0 + k]), 32'(exp_order[k]));
    end

    // A write immediately followed by a B read
    fork
      txn(1'b0, 1'b1, 2'b11, 18'h05000, 16'h7777, 16'h0000, 1'b0, "t4w");
      begin
        @(negedge iCLK);
        txn(1'b1, 1'b0, 2'b11, 18'h05001, 16'h0000, 16'h0A5B, 1'b0, "t4r");
      end
    join
    repeat (3) @(negedge iCLK);
    checks++;
    if (oen_fall_cyc - den_rise_cyc < 1) begin
      errors++;
      $display("FAIL t4_read_after_den_gap: got %0d cycles, required >= 1",
               oen_fall_cyc - den_rise_cyc);
    end

    // Reset asserted during the first write cycle
    a_we = 1'b1; a_be = 2'b11; a_addr = 18'h04000; a_wdata = 16'h1234; a_req = 1'b1;
    @(negedge iCLK);
    chk("t5_in_write", 32'(SRAM_WEn), 32'd0);
    s_aack = a_ack_cnt;
    #3 iRST_N = 1'b0;
    #1;
    chk("t5_async_strobes", 32'({SRAM_CEn, SRAM_OEn, SRAM_WEn, SRAM_LBn, SRAM_UBn, SRAM_DEn}), 32'h3F);
    chk("t5_async_ack", 32'({a_ack, b_ack}), 32'd0);
    a_req = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    repeat (3) @(negedge iCLK);
    chk("t5_no_ack_after_abort", 32'(a_ack_cnt - s_aack), 32'd0);
    txn(1'b0, 1'b0, 2'b11, 18'h04001, 16'h0000, 16'h1A5B, 1'b0, "t5_fresh_read");
    repeat (3) @(negedge iCLK);

    // Eight back-to-back A reads
    n0 = a_ack_cyc.size();
    for (int i = 0; i < 8; i++)
      txn(1'b0, 1'b0, 2'b11, 18'h01000 + 18'(3 * i), 16'h0, init_val(18'h01000 + 18'(3 * i)),
          i < 7, $sformatf("t6_%0d", i));
    repeat (3) @(negedge iCLK);
    chk("t6_ack_count", 32'(a_ack_cyc.size() - n0), 32'd8);
    for (int i = 1; i < 8; i++) begin
      if (n0 + i < a_ack_cyc.size())
        chk($sformatf("t6_ack_period%0d", i), 32'(a_ack_cyc[n0 + i] - a_ack_cyc[n0 + i - 1]), 32'd4);
    end

    chk("oe_de_overlap_cycles", 32'(conflicts), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
